// File: rtl/mem_dbus_ctrl_if.sv
// Signal bundle between the MEM pipeline stage, the data-bus controller and the data bus.
// The master modport is the controller's view; slave is the view of the pipeline/bus side.
interface mem_dbus_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_req_uncached;
  logic        mem_flush;
  logic        pipe_wr;
  logic        dbus_addr_ok;
  logic        dbus_data_ok;
  logic [31:0] dbus_rdata;
  logic        dbus_req;
  logic        dbus_wr;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_uncached;
  logic [31:0] mem2_rdata;
  logic        mem2_rdata_valid;
  logic        dbus_stall;
  logic        dbus_err;

  modport master (
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_uncached, mem_flush, pipe_wr, dbus_addr_ok, dbus_data_ok, dbus_rdata,
    output dbus_req, dbus_wr, dbus_addr, dbus_wdata, dbus_wstrb, dbus_uncached,
    output mem2_rdata, mem2_rdata_valid, dbus_stall, dbus_err
  );

  modport slave (
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_uncached, mem_flush, pipe_wr, dbus_addr_ok, dbus_data_ok, dbus_rdata,
    input  dbus_req, dbus_wr, dbus_addr, dbus_wdata, dbus_wstrb, dbus_uncached,
    input  mem2_rdata, mem2_rdata_valid, dbus_stall, dbus_err
  );
endinterface

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: one outstanding load/store, flush-drop handling and a
// watchdog that aborts a transfer stuck in REQ/WAIT for WATCHDOG cycles.
module mem_dbus_ctrl #(
  parameter int unsigned WATCHDOG = 255
) (
  input  logic clk,
  input  logic resetn,
  mem_dbus_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [9:0] WD_LIMIT = 10'(WATCHDOG);

  state_t      state_reg;
  logic        req_reg;
  logic        wr_reg;
  logic        uncached_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [31:0] rdata_reg;
  logic        valid_reg;
  logic        err_reg;
  logic        drop_reg;
  logic [9:0]  wd_reg;

  logic [9:0]  wd_inc;
  logic        accept;
  logic        dropped;

  assign wd_inc  = wd_reg + 10'd1;
  assign accept  = bus.mem_req_valid && !bus.mem_flush;
  // A flush in the completing cycle itself also discards the result.
  assign dropped = drop_reg || bus.mem_flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      wr_reg       <= 1'b0;
      uncached_reg <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      wstrb_reg    <= 4'd0;
      rdata_reg    <= 32'd0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      drop_reg     <= 1'b0;
      wd_reg       <= 10'd0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            wr_reg       <= bus.mem_req_wr;
            uncached_reg <= bus.mem_req_uncached;
            addr_reg     <= bus.mem_req_addr;
            wdata_reg    <= bus.mem_req_wdata;
            wstrb_reg    <= bus.mem_req_wstrb;
            req_reg      <= 1'b1;
            wd_reg       <= 10'd0;
            drop_reg     <= 1'b0;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_flush && !bus.dbus_addr_ok) begin
            req_reg   <= 1'b0;
            state_reg <= IDLE;
          end else if (bus.dbus_addr_ok && bus.dbus_data_ok) begin
            req_reg <= 1'b0;
            if (dropped) begin
              drop_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              rdata_reg <= bus.dbus_rdata;
              valid_reg <= 1'b1;
              state_reg <= DONE;
            end
          end else if (wd_inc == WD_LIMIT) begin
            req_reg   <= 1'b0;
            err_reg   <= 1'b1;
            drop_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            wd_reg <= wd_inc;
            if (bus.dbus_addr_ok) begin
              req_reg   <= 1'b0;
              drop_reg  <= bus.mem_flush;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.dbus_data_ok) begin
            if (dropped) begin
              drop_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              rdata_reg <= bus.dbus_rdata;
              valid_reg <= 1'b1;
              state_reg <= DONE;
            end
          end else if (wd_inc == WD_LIMIT) begin
            err_reg   <= 1'b1;
            drop_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            wd_reg <= wd_inc;
            if (bus.mem_flush) drop_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.pipe_wr) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.dbus_req         = req_reg;
  assign bus.dbus_wr          = wr_reg;
  assign bus.dbus_uncached    = uncached_reg;
  assign bus.dbus_addr        = addr_reg;
  assign bus.dbus_wdata       = wdata_reg;
  assign bus.dbus_wstrb       = wstrb_reg;
  assign bus.mem2_rdata       = rdata_reg;
  assign bus.mem2_rdata_valid = valid_reg;
  assign bus.dbus_err         = err_reg;

  // Stall starts combinationally in the cycle a request is seen so MEM holds it.
  assign bus.dbus_stall = (state_reg == REQ) || (state_reg == WAIT) ||
                          ((state_reg == IDLE) && accept);
endmodule
